// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: one stage per cycle, a memory stage held on
// a req/ack handshake with timeout, architectural status tracking and retire/cycle counters.
module seq_stage_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic             f_latch,
  output logic             d_latch,
  output logic             e_latch,
  output logic             cc_en,
  output logic             mem_req,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT
  } stateT;

  stateT           state, nextState;
  logic [2:0]      nextStat;
  logic [3:0]      icodeLatch;
  logic [TO_W-1:0] timeoutCnt;
  logic            isMemOp, isReadOp, isWriteOp;

  assign isReadOp  = (icodeLatch == 4'h5) || (icodeLatch == 4'h9) || (icodeLatch == 4'hB);
  assign isWriteOp = (icodeLatch == 4'h4) || (icodeLatch == 4'h8) || (icodeLatch == 4'hA);
  assign isMemOp   = isReadOp || isWriteOp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Status only changes on the transition into HALT, so it stays frozen afterwards.
  always_comb begin
    nextState = state;
    nextStat  = stat;
    case (state)
      IDLE:      if (start) nextState = FETCH;
      FETCH: begin
        if (imem_error) begin
          nextStat  = STAT_ADR;
          nextState = HALT;
        end else if (!instr_valid) begin
          nextStat  = STAT_INS;
          nextState = HALT;
        end else if (icode == 4'h0) begin
          nextStat  = STAT_HLT;
          nextState = HALT;
        end else begin
          nextState = DECODE;
        end
      end
      DECODE:    nextState = EXECUTE;
      EXECUTE:   nextState = isMemOp ? MEMORY : WRITEBACK;
      MEMORY: begin
        if (mem_ack) begin
          if (dmem_error) begin
            nextStat  = STAT_ADR;
            nextState = HALT;
          end else begin
            nextState = WRITEBACK;
          end
        end else if (timeoutCnt == TO_LAST) begin
          nextStat  = STAT_ADR;
          nextState = HALT;
        end
      end
      WRITEBACK: nextState = PCUPD;
      PCUPD:     nextState = FETCH;
      HALT:      nextState = HALT;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    f_latch = 1'b0;
    d_latch = 1'b0;
    e_latch = 1'b0;
    cc_en   = 1'b0;
    mem_req = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    wb_en   = 1'b0;
    pc_en   = 1'b0;
    busy    = 1'b1;
    halted  = 1'b0;
    case (state)
      IDLE:      busy = 1'b0;
      FETCH:     f_latch = 1'b1;
      DECODE:    d_latch = 1'b1;
      EXECUTE: begin
        e_latch = 1'b1;
        cc_en   = (icodeLatch == 4'h6);
      end
      MEMORY: begin
        mem_req = 1'b1;
        mem_rd  = isReadOp;
        mem_wr  = isWriteOp;
      end
      WRITEBACK: wb_en = 1'b1;
      PCUPD:     pc_en = 1'b1;
      HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default:   busy = 1'b0;
    endcase
  end

  // Timeout counter clears whenever we are not waiting on the data memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat        <= STAT_AOK;
      icodeLatch  <= 4'h0;
      timeoutCnt  <= '0;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      stat <= nextStat;
      if (state == FETCH) icodeLatch <= icode;
      if (state == MEMORY && !mem_ack) timeoutCnt <= timeoutCnt + 1'b1;
      else                             timeoutCnt <= '0;
      if (pc_en) instr_count <= instr_count + CNT_W'(1);
      if (busy)  cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Self-checking bench for seq_stage_controller: random instruction streams plus directed
// fault, timeout and reset cases against an instruction-level reference model.
module tb_seq_stage_controller;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n, start, instr_valid, imem_error, mem_ack, dmem_error;
  logic [3:0]       icode;
  logic             f_latch, d_latch, e_latch, cc_en, mem_req, mem_rd, mem_wr, wb_en, pc_en;
  logic             busy, halted;
  logic [2:0]       stat;
  logic [CNT_W-1:0] instr_count, cycle_count;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0]       modelStat;
  logic [CNT_W-1:0] modelInstr, modelCycle;
  logic             modelHalted;

  seq_stage_controller #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .f_latch(f_latch), .d_latch(d_latch), .e_latch(e_latch), .cc_en(cc_en),
    .mem_req(mem_req), .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_en(wb_en), .pc_en(pc_en),
    .stat(stat), .busy(busy), .halted(halted),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Vector layout: {f,d,e,cc,req,rd,wr,wb,pc,busy,halted,stat[2:0]}
  function automatic logic [13:0] mk(input logic f, d, e, cc, req, rd, wr, wb, pc, bz, hl);
    return {f, d, e, cc, req, rd, wr, wb, pc, bz, hl, modelStat};
  endfunction

  task automatic checkOutput(input logic [13:0] exp, input string tag);
    logic [13:0] obs;
    obs = {f_latch, d_latch, e_latch, cc_en, mem_req, mem_rd, mem_wr, wb_en, pc_en,
           busy, halted, stat};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs, exp);
    end
    compared++;
    assert (instr_count === modelInstr) else begin
      mismatched++;
      $error("FAIL %s instr_count: observed %0d expected %0d", tag, instr_count, modelInstr);
    end
    compared++;
    assert (cycle_count === modelCycle) else begin
      mismatched++;
      $error("FAIL %s cycle_count: observed %0d expected %0d", tag, cycle_count, modelCycle);
    end
  endtask

  // Check the current cycle, drive this cycle's inputs, then advance one clock.
  task automatic applyStimulus(input logic [13:0] exp, input string tag, input logic [3:0] ic,
                               input logic v, ie, ack, de, st);
    checkOutput(exp, tag);
    icode       = ic;
    instr_valid = v;
    imem_error  = ie;
    mem_ack     = ack;
    dmem_error  = de;
    start       = st;
    @(posedge clk);
    #1;
    if (exp[4]) modelCycle++;
    if (exp[5]) modelInstr++;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start = 1'b0; icode = 4'h0; instr_valid = 1'b0; imem_error = 1'b0;
    mem_ack = 1'b0; dmem_error = 1'b0;
    modelStat = 3'd1; modelInstr = '0; modelCycle = '0; modelHalted = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(mk(0,0,0,0,0,0,0,0,0,0,0), "reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0), "idle", 4'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One instruction at ISA level; ackAt = MEMORY cycle that acks (0 = never).
  task automatic runInstr(input logic [3:0] c, input logic v, ie, input int ackAt, input logic de);
    logic isRd, isWr, ack, dErr;
    applyStimulus(mk(1,0,0,0,0,0,0,0,0,1,0), "fetch", c, v, ie, 1'b0, 1'b0, 1'($urandom));
    if (ie)            begin modelStat = 3'd3; modelHalted = 1'b1; return; end
    else if (!v)       begin modelStat = 3'd4; modelHalted = 1'b1; return; end
    else if (c == 4'h0) begin modelStat = 3'd2; modelHalted = 1'b1; return; end
    isRd = (c == 4'h5) || (c == 4'h9) || (c == 4'hB);
    isWr = (c == 4'h4) || (c == 4'h8) || (c == 4'hA);
    applyStimulus(mk(0,1,0,0,0,0,0,0,0,1,0), "decode", 4'($urandom), 1'($urandom),
                  1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    applyStimulus(mk(0,0,1,(c == 4'h6),0,0,0,0,0,1,0), "execute", 4'($urandom), 1'($urandom),
                  1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    if (isRd || isWr) begin
      for (int k = 1; k <= 15; k++) begin
        ack  = (k == ackAt);
        dErr = ack ? de : 1'($urandom);
        applyStimulus(mk(0,0,0,0,1,isRd,isWr,0,0,1,0), "memory", 4'($urandom), 1'($urandom),
                      1'($urandom), ack, dErr, 1'($urandom));
        if (ack) begin
          if (de) begin modelStat = 3'd3; modelHalted = 1'b1; return; end
          break;
        end
        if (k == 15) begin modelStat = 3'd3; modelHalted = 1'b1; return; end
      end
    end
    applyStimulus(mk(0,0,0,0,0,0,0,1,0,1,0), "writeback", 4'($urandom), 1'($urandom),
                  1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    applyStimulus(mk(0,0,0,0,0,0,0,0,1,1,0), "pcupd", 4'($urandom), 1'($urandom),
                  1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic checkHalt(input string tag, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,1), tag, 4'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    logic [3:0] c;
    doReset();
    runInstr(4'h1, 1'b1, 1'b0, 0, 1'b0);
    runInstr(4'h6, 1'b1, 1'b0, 0, 1'b0);
    runInstr(4'h5, 1'b1, 1'b0, 3, 1'b0);
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(1, 11));
      runInstr(c, 1'b1, 1'b0, int'($urandom_range(1, 4)), 1'b0);
    end

    // Reset while the memory stage is waiting
    doReset();
    applyStimulus(mk(1,0,0,0,0,0,0,0,0,1,0), "fetch", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mk(0,1,0,0,0,0,0,0,0,1,0), "decode", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mk(0,0,1,0,0,0,0,0,0,1,0), "execute", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(mk(0,0,0,0,1,1,0,0,0,1,0), "memBeforeRst");
    rst_n = 1'b0;
    modelInstr = '0; modelCycle = '0; modelStat = 3'd1;
    #1;
    checkOutput(mk(0,0,0,0,0,0,0,0,0,0,0), "rstInMemory");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0), "idleNoStart", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0), "idleStart", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    runInstr(4'h2, 1'b1, 1'b0, 0, 1'b0);
    runInstr(4'h4, 1'b1, 1'b0, 0, 1'b0);
    checkHalt("haltTimeout", 3);

    doReset();
    runInstr(4'h1, 1'b1, 1'b0, 0, 1'b0);
    runInstr(4'h3, 1'b0, 1'b0, 0, 1'b0);
    checkHalt("haltIns", 2);

    doReset();
    runInstr(4'h0, 1'b1, 1'b0, 0, 1'b0);
    checkHalt("haltHlt", 2);

    doReset();
    runInstr(4'h2, 1'b0, 1'b1, 0, 1'b0);
    checkHalt("haltImem", 2);

    doReset();
    runInstr(4'hB, 1'b1, 1'b0, 2, 1'b1);
    checkHalt("haltDmem", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
